// File: rtl/div_wide.sv
// Sequential radix-2 restoring divider: WN-bit dividend / W-bit divisor, one quotient bit per cycle.
// Optional WD_DIV_WIDE_DZ_FAST_EN: zero divisor detected at accept, result in one cycle with dz_o=1.
module div_wide #(
  parameter int W  = 256,
  parameter int WN = 2*W,
  parameter int M  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] in0,
  input  logic [W-1:0]  in1,
  input  logic [M-1:0]  m_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WN-1:0] q_o,
  output logic [W-1:0]  r_o,
  output logic          dz_o,
  output logic [M-1:0]  m_o
);
  localparam int CW = (WN > 1) ? $clog2(WN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  // dvd holds the unconsumed dividend in its upper bits and the quotient in its lower bits
  logic [WN-1:0] dvd;
  logic [W-1:0]  dsr;
  logic [W-1:0]  rem;
  logic [M-1:0]  meta;
  logic [CW-1:0] cnt;

  logic [W:0]    t;
  logic          ge;
  logic [W-1:0]  rem_nxt;
  logic [WN-1:0] dvd_nxt;

  // When ge holds the true difference is below dsr, so a W-bit subtract is exact
  assign t       = {rem, dvd[WN-1]};
  assign ge      = t >= {1'b0, dsr};
  assign rem_nxt = ge ? (t[W-1:0] - dsr) : t[W-1:0];
  assign dvd_nxt = {dvd[WN-2:0], ge};

  assign in_ready = (state == IDLE) && !rst;

`ifdef WD_DIV_WIDE_DZ_FAST_EN
  logic dz_q;
  assign dz_o = dz_q;
`else
  assign dz_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      q_o       <= '0;
      r_o       <= '0;
      m_o       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      meta      <= '0;
      cnt       <= '0;
`ifdef WD_DIV_WIDE_DZ_FAST_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef WD_DIV_WIDE_DZ_FAST_EN
            if (in1 == '0) begin
              q_o       <= '1;
              r_o       <= in0[W-1:0];
              m_o       <= m_i;
              dz_q      <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else
`endif
            begin
              dvd   <= in0;
              dsr   <= in1;
              meta  <= m_i;
              rem   <= '0;
              cnt   <= CW'(WN-1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          if (cnt == '0) begin
            q_o       <= dvd_nxt;
            r_o       <= rem_nxt;
            m_o       <= meta;
`ifdef WD_DIV_WIDE_DZ_FAST_EN
            dz_q      <= 1'b0;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_wide.sv
// Directed and randomized checks of div_wide at W=8/WN=16 and W=256/WN=512.
module tb_div_wide;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, dz_o;
  logic [15:0] in0, q_o;
  logic [7:0]  in1, r_o;
  logic [3:0]  m_i, m_o;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_dz_o;
  logic [511:0] w_in0, w_q_o;
  logic [255:0] w_in1, w_r_o;
  logic [31:0]  w_m_i, w_m_o;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  div_wide #(.W(8), .WN(16), .M(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .m_i(m_i), .out_valid(out_valid), .out_ready(out_ready),
    .q_o(q_o), .r_o(r_o), .dz_o(dz_o), .m_o(m_o)
  );

  div_wide #(.W(256), .WN(512), .M(32)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in0(w_in0), .in1(w_in1), .m_i(w_m_i), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .q_o(w_q_o), .r_o(w_r_o), .dz_o(w_dz_o), .m_o(w_m_o)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accept
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [3:0] m);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("issue_ready", in_ready, 1);
    in_valid = 1'b1; in0 = a; in1 = b; m_i = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic done;
    logic [15:0] a, ea;
    logic [7:0]  b, er;
    logic [3:0]  m;
    logic [511:0] wa, wq;
    logic [255:0] wb, wr;
    logic [31:0]  wm;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in0 = '0; in1 = '0; m_i = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in0 = '0; w_in1 = '0; w_m_i = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q_o, 0);
    chk("rst_r", r_o, 0);
    chk("rst_m", m_o, 0);
    chk("rst_dz", dz_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // basic divide
    issue(16'h1234, 8'h07, 4'h5);
    wait_out(lat);
    chk("basic_lat", lat, 17);
    chk("basic_q", q_o, 16'h0299);
    chk("basic_r", r_o, 8'h05);
    chk("basic_m", m_o, 4'h5);
    chk("basic_dz", dz_o, 0);
    chk("basic_in_ready", in_ready, 0);
    @(negedge clk);
    chk("basic_drop", out_valid, 0);

    // boundaries
    issue(16'hFFFF, 8'h01, 4'h1); wait_out(lat);
    chk("b1_lat", lat, 17); chk("b1_q", q_o, 16'hFFFF); chk("b1_r", r_o, 8'h00);
    issue(16'hFFFF, 8'hFF, 4'h2); wait_out(lat);
    chk("b2_q", q_o, 16'h0101); chk("b2_r", r_o, 8'h00); chk("b2_m", m_o, 4'h2);
    issue(16'h0005, 8'hFF, 4'h3); wait_out(lat);
    chk("b3_q", q_o, 16'h0000); chk("b3_r", r_o, 8'h05);

    // divide by zero
    issue(16'hABCD, 8'h00, 4'hA); wait_out(lat);
`ifdef WD_DIV_WIDE_DZ_FAST_EN
    chk("dz_lat", lat, 1); chk("dz_flag", dz_o, 1);
`else
    chk("dz_lat", lat, 17); chk("dz_flag", dz_o, 0);
`endif
    chk("dz_q", q_o, 16'hFFFF); chk("dz_r", r_o, 8'hCD); chk("dz_m", m_o, 4'hA);
    @(negedge clk);

    // backpressure with a competing request held during DONE
    out_ready = 1'b0;
    issue(16'h1234, 8'h07, 4'h9); wait_out(lat);
    chk("bp_lat", lat, 17);
    in_valid = 1'b1; in0 = 16'h0100; in1 = 8'h10; m_i = 4'h3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_q", q_o, 16'h0299);
      chk("bp_r", r_o, 8'h05);
      chk("bp_m", m_o, 4'h9);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_hold_q", q_o, 16'h0299);
    @(negedge clk);
    chk("bp_after_hs_valid", out_valid, 0);
    chk("bp_after_hs_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp2_lat", lat, 17); chk("bp2_q", q_o, 16'h0010); chk("bp2_r", r_o, 8'h00); chk("bp2_m", m_o, 4'h3);
    @(negedge clk);

    // reset mid-operation
    issue(16'h1234, 8'h07, 4'h6);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_q", q_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_in_ready_after", in_ready, 1);
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) done = 1'b1;
      @(negedge clk);
    end
    chk("mr_no_pulse", done, 0);
    issue(16'h0100, 8'h10, 4'h7); wait_out(lat);
    chk("mr_next_lat", lat, 17); chk("mr_next_q", q_o, 16'h0010); chk("mr_next_r", r_o, 8'h00);
    @(negedge clk);

    // random regression, random out_ready
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      m = 4'($urandom);
      ea = a / {8'd0, b};
      er = 8'(a % {8'd0, b});
      issue(a, b, m);
      n = 0; done = 1'b0;
      while (!done && n < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          chk("rnd_q", q_o, ea);
          chk("rnd_r", r_o, er);
          chk("rnd_m", m_o, m);
          chk("rnd_inv", 32'(q_o) * 32'(b) + 32'(r_o), 32'(a));
          chk("rnd_r_lt_b", r_o < b, 1);
          done = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      chk("rnd_timeout", done, 1);
    end
    out_ready = 1'b1;

    // wide instance
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 16; j++) wa[j*32 +: 32] = $urandom;
      if (k % 3 == 1) wb = 256'($urandom);
      else for (int j = 0; j < 8; j++) wb[j*32 +: 32] = $urandom;
      if (wb == '0) wb = 256'd1;
      wm = $urandom;
      wq = wa / {256'd0, wb};
      wr = 256'(wa % {256'd0, wb});
      n = 0;
      while (!w_in_ready && n < 100) begin @(negedge clk); n++; end
      chk("w_issue_ready", w_in_ready, 1);
      w_in_valid = 1'b1; w_in0 = wa; w_in1 = wb; w_m_i = wm;
      @(negedge clk);
      w_in_valid = 1'b0;
      lat = 1;
      while (!w_out_valid && lat < 1000) begin @(negedge clk); lat++; end
      chk("w_lat", lat, 513);
      chk("w_q", w_q_o, wq);
      chk("w_r", w_r_o, wr);
      chk("w_m", w_m_o, wm);
      chk("w_r_lt_b", w_r_o < wb, 1);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
